// File: rtl/reg_file_pkg.sv
// Shared constants and byte-lane / address helpers for the reg_file storage block.
package reg_file_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_DEPTH  = 8;

    // Widest entry the merge helper handles; callers extend into it and truncate back.
    localparam int unsigned MAX_DATA_W = 256;
    localparam int unsigned MAX_STRB_W = MAX_DATA_W / 8;

    function automatic logic [MAX_DATA_W-1:0] strb_merge(
        input logic [MAX_DATA_W-1:0] old_val,
        input logic [MAX_DATA_W-1:0] new_val,
        input logic [MAX_STRB_W-1:0] strb
    );
        logic [MAX_DATA_W-1:0] res;
        res = old_val;
        for (int unsigned i = 0; i < MAX_STRB_W; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

    function automatic logic addr_valid(
        input logic [31:0] addr,
        input int unsigned depth,
        input logic        zero_reg
    );
        return (addr < depth) && !(zero_reg && (addr == 32'd0));
    endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read mux: range check, zero-register masking and, when
// REG_FILE_BYPASS_EN is defined, same-cycle forwarding of the merged write data.
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned ZERO_REG = 0,
    localparam int unsigned ADDR_W  = $clog2(DEPTH)
) (
    input  logic [DATA_W-1:0] mem [DEPTH],
`ifdef REG_FILE_BYPASS_EN
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wr_merged,
`endif
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    always_comb begin
        rdata = '0;
        if ((32'(raddr) < DEPTH) && !((ZERO_REG != 0) && (raddr == '0))) begin
            rdata = mem[raddr];
        end
`ifdef REG_FILE_BYPASS_EN
        // wr_valid already excludes clr, out-of-range and the zero register
        if (wr_valid && (raddr == waddr)) begin
            rdata = wr_merged;
        end
`endif
    end

endmodule

// File: rtl/reg_file.sv
// DEPTH x DATA_W register file: one byte-strobed write port, two combinational
// read ports, sync clear, written-flag bitmap. Optional bypass: REG_FILE_BYPASS_EN.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned ZERO_REG = 0,
    localparam int unsigned ADDR_W  = $clog2(DEPTH),
    localparam int unsigned STRB_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              clr,
    input  logic [ADDR_W-1:0] raddr0,
    output logic [DATA_W-1:0] rdata0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    output logic [DEPTH-1:0]  wr_flags
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_valid;
    logic [DATA_W-1:0] wr_old;
    logic [DATA_W-1:0] wr_merged;

    always_comb begin
        wr_valid = we && !clr && (wstrb != '0)
                   && addr_valid(32'(waddr), DEPTH, ZERO_REG != 0);
        wr_old = '0;
        if (32'(waddr) < DEPTH) begin
            wr_old = mem[waddr];
        end
        wr_merged = DATA_W'(strb_merge(MAX_DATA_W'(wr_old), MAX_DATA_W'(wdata),
                                       MAX_STRB_W'(wstrb)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_flags <= '0;
        end else if (clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_flags <= '0;
        end else if (wr_valid) begin
            mem[waddr]      <= wr_merged;
            wr_flags[waddr] <= 1'b1;
        end
    end

    reg_file_rd_port #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_rd0 (
        .mem       (mem),
`ifdef REG_FILE_BYPASS_EN
        .wr_valid  (wr_valid),
        .waddr     (waddr),
        .wr_merged (wr_merged),
`endif
        .raddr     (raddr0),
        .rdata     (rdata0)
    );

    reg_file_rd_port #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_rd1 (
        .mem       (mem),
`ifdef REG_FILE_BYPASS_EN
        .wr_valid  (wr_valid),
        .waddr     (waddr),
        .wr_merged (wr_merged),
`endif
        .raddr     (raddr1),
        .rdata     (rdata1)
    );

endmodule
